// File: rtl/jt6295_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt6295_pkg : sequencer state encoding and default sizing               |
// | Revision   : 1.0                                                       |
// +-------------------------------------------------------------------------+
package jt6295_pkg;
  localparam int CH_DEF = 4;
  localparam int AW_DEF = 18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;
endpackage
`default_nettype wire

// File: rtl/jt6295_pcmseq_regs.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt6295_pcmseq_regs : per-voice pending/active registers, nibble pointers|
// | Revision           : 1.0                                               |
// +-------------------------------------------------------------------------+
module jt6295_pcmseq_regs
  import jt6295_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = 2
)(
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] start_sel,
  input  logic [CH-1:0] stop,
  input  logic [CH-1:0] loop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    att,
  input  logic          load,
  input  logic          adv,
  input  logic          fetch_we,
  input  logic [CW-1:0] k,
  input  logic [7:0]    rom_data,
  output logic [CH-1:0] busy,
  output logic [AW-1:0] cur_addr,
  output logic          cur_nib,
  output logic          cur_first,
  output logic [3:0]    cur_att,
  output logic [7:0]    cur_byte
);

  logic [AW-1:0] psa_q [CH];
  logic [AW-1:0] psa_d [CH];
  logic [AW-1:0] pea_q [CH];
  logic [AW-1:0] pea_d [CH];
  logic [AW-1:0] asa_q [CH];
  logic [AW-1:0] asa_d [CH];
  logic [AW-1:0] aea_q [CH];
  logic [AW-1:0] aea_d [CH];
  logic [3:0]    patt_q [CH];
  logic [3:0]    patt_d [CH];
  logic [3:0]    aatt_q [CH];
  logic [3:0]    aatt_d [CH];
  logic [AW:0]   ptr_q [CH];
  logic [AW:0]   ptr_d [CH];
  logic [7:0]    byte_q [CH];
  logic [7:0]    byte_d [CH];
  logic [CH-1:0] plp_q, plp_d, alp_q, alp_d;
  logic [CH-1:0] pstart_q, pstart_d, pstop_q, pstop_d;
  logic [CH-1:0] busy_q, busy_d, first_q, first_d;

  always_comb begin
    pstart_d = (load ? {CH{1'b0}} : pstart_q) | start_sel;
    pstop_d  = (load ? {CH{1'b0}} : pstop_q) | stop;
    psa_d = psa_q;  pea_d = pea_q;  patt_d = patt_q;  plp_d = plp_q;
    asa_d = asa_q;  aea_d = aea_q;  aatt_d = aatt_q;  alp_d = alp_q;
    ptr_d = ptr_q;  byte_d = byte_q;
    busy_d = busy_q;
    first_d = first_q;
    for (int v = 0; v < CH; v++) begin
      if (start_sel[v]) begin
        psa_d[v]  = start_addr;
        pea_d[v]  = stop_addr;
        patt_d[v] = att;
        plp_d[v]  = loop[v];
      end
      // A pending stop wins over a pending start on the same voice
      if (load && pstop_q[v]) begin
        busy_d[v] = 1'b0;
      end else if (load && pstart_q[v]) begin
        busy_d[v]  = 1'b1;
        asa_d[v]   = psa_q[v];
        aea_d[v]   = pea_q[v];
        aatt_d[v]  = patt_q[v];
        alp_d[v]   = plp_q[v];
        ptr_d[v]   = {psa_q[v], 1'b0};
        first_d[v] = 1'b1;
      end
    end
    if (fetch_we) begin
      byte_d[k] = rom_data;
    end
    if (adv) begin
      if (ptr_q[k] == {aea_q[k], 1'b1}) begin
        if (alp_q[k]) begin
          ptr_d[k]   = {asa_q[k], 1'b0};
          first_d[k] = 1'b1;
        end else begin
          busy_d[k] = 1'b0;
        end
      end else begin
        // Pointer wraps naturally at AW bits, so start > stop plays through zero
        ptr_d[k]   = ptr_q[k] + (AW+1)'(1);
        first_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstart_q <= '0;
      pstop_q  <= '0;
      busy_q   <= '0;
      first_q  <= '0;
      plp_q    <= '0;
      alp_q    <= '0;
      for (int v = 0; v < CH; v++) begin
        psa_q[v]  <= '0;
        pea_q[v]  <= '0;
        asa_q[v]  <= '0;
        aea_q[v]  <= '0;
        patt_q[v] <= '0;
        aatt_q[v] <= '0;
        ptr_q[v]  <= '0;
        byte_q[v] <= '0;
      end
    end else begin
      pstart_q <= pstart_d;
      pstop_q  <= pstop_d;
      busy_q   <= busy_d;
      first_q  <= first_d;
      plp_q    <= plp_d;
      alp_q    <= alp_d;
      psa_q    <= psa_d;
      pea_q    <= pea_d;
      asa_q    <= asa_d;
      aea_q    <= aea_d;
      patt_q   <= patt_d;
      aatt_q   <= aatt_d;
      ptr_q    <= ptr_d;
      byte_q   <= byte_d;
    end
  end

  assign busy      = busy_q;
  assign cur_addr  = ptr_q[k][AW:1];
  assign cur_nib   = ptr_q[k][0];
  assign cur_first = first_q[k];
  assign cur_att   = aatt_q[k];
  assign cur_byte  = byte_q[k];

endmodule
`default_nettype wire

// File: rtl/jt6295_pcmseq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | jt6295_pcmseq : frame sequencer feeding ROM nibbles to an ADPCM decoder|
// | Revision      : 1.0                                                    |
// +-------------------------------------------------------------------------+
module jt6295_pcmseq
  import jt6295_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int AW = AW_DEF,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [CH-1:0] start,
  input  logic [CH-1:0] stop,
  input  logic [CH-1:0] loop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    att,
  output logic [CH-1:0] busy,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic          pipe_en,
  output logic [CW-1:0] pipe_ch,
  output logic [3:0]    pipe_att,
  output logic [3:0]    pipe_data,
  output logic          pipe_first,
  output logic          ovr
);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CH-1:0] start_sel;
  logic          last, load, adv, fetch_we;
  logic [AW-1:0] cur_addr;
  logic          cur_nib, cur_first;
  logic [3:0]    cur_att;
  logic [7:0]    cur_byte;
  logic [CW-1:0] pipe_ch_q, pipe_ch_d;
  logic [3:0]    pipe_att_q, pipe_att_d, pipe_data_q, pipe_data_d;
  logic          pipe_first_q, pipe_first_d, ovr_q, ovr_d;

  // Isolate the lowest set start bit; the rest are dropped
  assign start_sel = start & (~start + CH'(1));
  assign last      = (k_q == CW'(CH-1));

  jt6295_pcmseq_regs #(.CH(CH), .AW(AW), .CW(CW)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .start_sel  (start_sel),
    .stop       (stop),
    .loop       (loop),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .att        (att),
    .load       (load),
    .adv        (adv),
    .fetch_we   (fetch_we),
    .k          (k_q),
    .rom_data   (rom_data),
    .busy       (busy),
    .cur_addr   (cur_addr),
    .cur_nib    (cur_nib),
    .cur_first  (cur_first),
    .cur_att    (cur_att),
    .cur_byte   (cur_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (cen) begin
          state_d = ST_SCAN;
          k_d     = '0;
        end
      end
      ST_SCAN: begin
        if (!busy[k_q]) begin
          if (last) state_d = ST_IDLE;
          else      k_d     = k_q + CW'(1);
        end else begin
          state_d = cur_nib ? ST_EMIT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rom_ok) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN;
          k_d     = k_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipe fields are loaded on entry to EMIT so they are valid while pipe_en is high
  always_comb begin
    load         = 1'b0;
    adv          = 1'b0;
    rom_cs       = 1'b0;
    fetch_we     = 1'b0;
    pipe_ch_d    = pipe_ch_q;
    pipe_att_d   = pipe_att_q;
    pipe_data_d  = pipe_data_q;
    pipe_first_d = pipe_first_q;
    ovr_d        = cen && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: load = cen;
      ST_SCAN: begin
        if (busy[k_q] && cur_nib) begin
          pipe_ch_d    = k_q;
          pipe_att_d   = cur_att;
          pipe_first_d = cur_first;
          pipe_data_d  = cur_byte[3:0];
        end
      end
      ST_FETCH: begin
        rom_cs = 1'b1;
        if (rom_ok) begin
          fetch_we     = 1'b1;
          pipe_ch_d    = k_q;
          pipe_att_d   = cur_att;
          pipe_first_d = cur_first;
          pipe_data_d  = rom_data[7:4];
        end
      end
      ST_EMIT: adv = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_ch_q    <= '0;
      pipe_att_q   <= '0;
      pipe_data_q  <= '0;
      pipe_first_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      pipe_ch_q    <= pipe_ch_d;
      pipe_att_q   <= pipe_att_d;
      pipe_data_q  <= pipe_data_d;
      pipe_first_q <= pipe_first_d;
      ovr_q        <= ovr_d;
    end
  end

  assign rom_addr   = rom_cs ? cur_addr : '0;
  assign pipe_en    = adv;
  assign pipe_ch    = pipe_ch_q;
  assign pipe_att   = pipe_att_q;
  assign pipe_data  = pipe_data_q;
  assign pipe_first = pipe_first_q;
  assign ovr        = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_jt6295_pcmseq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_jt6295_pcmseq : self-checking bench with emission/fetch scoreboards |
// | Revision         : 1.0                                                 |
// +-------------------------------------------------------------------------+
module tb_jt6295_pcmseq;
  localparam int CH = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [CH-1:0] start = '0, stop = '0, loop = '0;
  logic [AW-1:0] start_addr = '0, stop_addr = '0;
  logic [3:0]    att = '0;
  logic [CH-1:0] busy;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok = 1'b0;
  logic          pipe_en;
  logic [1:0]    pipe_ch;
  logic [3:0]    pipe_att, pipe_data;
  logic          pipe_first;
  logic          ovr;

  logic          stall = 1'b0;
  logic [7:0]    mem [0:1023];
  int            checks = 0, errors = 0;
  int            ovr_cnt = 0, cs_cnt = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
    logic       first;
    logic [3:0] att;
  } emit_t;

  typedef struct {
    logic [1:0]  ch;
    logic [9:0]  sa;
    logic [9:0]  ea;
    logic        lp;
    logic [3:0]  att;
    int          nfr;
    int          nem;
    logic [31:0] nibs;
    logic [7:0]  firsts;
    int          nfe;
    logic [39:0] fe;
    logic [3:0]  busy_end;
  } vec_t;

  emit_t         sb [$];
  logic [AW-1:0] fq [$];
  vec_t          tbl [5];

  jt6295_pcmseq #(.CH(CH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .att        (att),
    .busy       (busy),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .pipe_en    (pipe_en),
    .pipe_ch    (pipe_ch),
    .pipe_att   (pipe_att),
    .pipe_data  (pipe_data),
    .pipe_first (pipe_first),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  // ROM answers one cycle after a request unless stalled
  assign rom_data = mem[rom_addr];
  always @(posedge clk) rom_ok <= rom_cs && !rom_ok && !stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cen_pulse();
    @(posedge clk); #1 cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
  endtask

  task automatic frame();
    cen_pulse();
    repeat (19) @(posedge clk);
  endtask

  task automatic start_voice(input logic [1:0] ch, input logic [9:0] sa, input logic [9:0] ea,
                             input logic lp, input logic [3:0] at);
    @(posedge clk); #1;
    start_addr = sa;
    stop_addr  = ea;
    att        = at;
    loop       = '0;
    loop[ch]   = lp;
    start      = CH'(1) << ch;
    @(posedge clk); #1;
    start = '0;
    loop  = '0;
  endtask

  task automatic stop_all();
    @(posedge clk); #1 stop = '1;
    @(posedge clk); #1 stop = '0;
    frame();
  endtask

  emit_t         em, ep;
  logic          cs_prev = 1'b0, unstable = 1'b0;
  logic [AW-1:0] addr_prev = '0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    mem[10'h100] = 8'h12;  mem[10'h101] = 8'h34;
    mem[10'h3FF] = 8'hAB;  mem[10'h000] = 8'hCD;
    mem[10'h200] = 8'h5E;  mem[10'h201] = 8'h6F;  mem[10'h202] = 8'h70;
    mem[10'h300] = 8'h9C;

    tbl[0] = '{ch:2'd1, sa:10'h100, ea:10'h101, lp:1'b0, att:4'd3, nfr:5, nem:4,
               nibs:32'h4321, firsts:8'b0001, nfe:2,
               fe:{10'h0, 10'h0, 10'h101, 10'h100}, busy_end:4'b0000};
    tbl[1] = '{ch:2'd1, sa:10'h100, ea:10'h101, lp:1'b1, att:4'd5, nfr:5, nem:5,
               nibs:32'h14321, firsts:8'b10001, nfe:3,
               fe:{10'h0, 10'h100, 10'h101, 10'h100}, busy_end:4'b0010};
    tbl[2] = '{ch:2'd0, sa:10'h3FF, ea:10'h000, lp:1'b0, att:4'd0, nfr:5, nem:4,
               nibs:32'hDCBA, firsts:8'b0001, nfe:2,
               fe:{10'h0, 10'h0, 10'h000, 10'h3FF}, busy_end:4'b0000};
    tbl[3] = '{ch:2'd3, sa:10'h200, ea:10'h202, lp:1'b0, att:4'd9, nfr:7, nem:6,
               nibs:32'h07F6E5, firsts:8'b0001, nfe:3,
               fe:{10'h0, 10'h202, 10'h201, 10'h200}, busy_end:4'b0000};
    tbl[4] = '{ch:2'd2, sa:10'h300, ea:10'h300, lp:1'b1, att:4'd15, nfr:4, nem:4,
               nibs:32'hC9C9, firsts:8'b0101, nfe:2,
               fe:{10'h0, 10'h0, 10'h300, 10'h300}, busy_end:4'b0100};

    fork
      forever begin
        @(negedge clk);
        if (ovr) ovr_cnt++;
        if (rom_cs) cs_cnt++;
        if (pipe_en) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_emit: ch %0d data %0h first %0b, nothing expected",
                     pipe_ch, pipe_data, pipe_first);
          end else begin
            em = sb.pop_front();
            chk("emit_ch", 32'(pipe_ch), 32'(em.ch));
            chk("emit_data", 32'(pipe_data), 32'(em.data));
            chk("emit_first", 32'(pipe_first), 32'(em.first));
            chk("emit_att", 32'(pipe_att), 32'(em.att));
          end
        end
        if (rom_cs && !cs_prev) begin
          if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_fetch: addr %0h, nothing expected", rom_addr);
          end else begin
            chk("fetch_addr", 32'(rom_addr), 32'(fq.pop_front()));
          end
        end
        if (rom_cs && cs_prev && rom_addr != addr_prev) unstable = 1'b1;
        if (!rom_cs && cs_prev) begin
          chk("rom_addr_stable", 32'(unstable), 32'd0);
          unstable = 1'b0;
        end
        cs_prev   = rom_cs;
        addr_prev = rom_addr;
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pipe", {pipe_en, pipe_ch, pipe_att, pipe_data, pipe_first}, 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int t = 0; t < 5; t++) begin
      ovr_cnt = 0;
      for (int i = 0; i < tbl[t].nfe; i++) fq.push_back(tbl[t].fe[10*i +: 10]);
      start_voice(tbl[t].ch, tbl[t].sa, tbl[t].ea, tbl[t].lp, tbl[t].att);
      for (int f = 0; f < tbl[t].nfr; f++) begin
        if (f < tbl[t].nem) begin
          ep.ch    = tbl[t].ch;
          ep.data  = tbl[t].nibs[4*f +: 4];
          ep.first = tbl[t].firsts[f];
          ep.att   = tbl[t].att;
          sb.push_back(ep);
        end
        frame();
      end
      chk("busy_end", 32'(busy), 32'(tbl[t].busy_end));
      chk("emits_drained", sb.size(), 32'd0);
      chk("fetches_drained", fq.size(), 32'd0);
      chk("no_ovr", ovr_cnt, 32'd0);
      stop_all();
      chk("busy_after_stop", 32'(busy), 32'd0);
    end

    // Simultaneous starts with a stop on the losing voice
    fq.push_back(10'h100);
    ep = '{ch:2'd1, data:4'h1, first:1'b1, att:4'd2};
    sb.push_back(ep);
    @(posedge clk); #1;
    start_addr = 10'h100; stop_addr = 10'h101; att = 4'd2;
    start = 4'b0110; stop = 4'b0100;
    @(posedge clk); #1;
    start = '0; stop = '0;
    frame();
    chk("conflict_busy", 32'(busy), 32'b0010);
    chk("conflict_emits", sb.size(), 32'd0);
    stop_all();

    // ROM stall longer than a frame period
    ovr_cnt = 0;
    fq.push_back(10'h100);
    fq.push_back(10'h101);
    ep = '{ch:2'd1, data:4'h1, first:1'b1, att:4'd6}; sb.push_back(ep);
    ep = '{ch:2'd1, data:4'h2, first:1'b0, att:4'd6}; sb.push_back(ep);
    ep = '{ch:2'd1, data:4'h3, first:1'b0, att:4'd6}; sb.push_back(ep);
    ep = '{ch:2'd1, data:4'h4, first:1'b0, att:4'd6}; sb.push_back(ep);
    start_voice(2'd1, 10'h100, 10'h101, 1'b0, 4'd6);
    stall = 1'b1;
    cen_pulse();
    repeat (39) @(posedge clk);
    cen_pulse();
    repeat (11) @(posedge clk);
    #1 stall = 1'b0;
    repeat (28) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      cen_pulse();
      repeat (39) @(posedge clk);
    end
    chk("stall_ovr_count", ovr_cnt, 32'd1);
    chk("stall_busy", 32'(busy), 32'd0);
    chk("stall_emits", sb.size(), 32'd0);
    chk("stall_fetches", fq.size(), 32'd0);

    // Reset while a fetch is outstanding
    fq.push_back(10'h100);
    stall = 1'b1;
    start_voice(2'd0, 10'h100, 10'h101, 1'b0, 4'd7);
    cen_pulse();
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_rom_cs", 32'(rom_cs), 32'd1);
    chk("pre_rst_rom_addr", 32'(rom_addr), 32'h100);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rom_cs", 32'(rom_cs), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_pipe", {pipe_en, pipe_ch, pipe_att, pipe_data, pipe_first}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    stall = 1'b0;
    cs_cnt = 0;
    repeat (10) @(posedge clk);
    frame();
    chk("post_rst_no_cs", cs_cnt, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_fetches", fq.size(), 32'd0);
    chk("final_emits", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
